fetch_ctrl: RTL

Fetch sequencer for the instruction memory. Generates the PC stream and read enables for the one-word-per-cycle instruction memory, tracks its fixed read latency, buffers returned words in a small FIFO, and presents `{pc, instr}` to decode over a valid/ready handshake. Branch/jump redirects squash in-flight and buffered fetches. A halt request stops new issue while allowing in-flight fetches to drain.

---
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with read-latency tracking and a show-ahead
// instruction buffer between the instruction memory and decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] imem_index,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic          r_issued [LATENCY];
  logic          r_live   [LATENCY];
  logic [31:0]   r_spc    [LATENCY];
  logic [31:0]   r_fpc    [FIFO_DEPTH];
  logic [31:0]   r_finstr [FIFO_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [CW-1:0] w_inflight;
  logic          w_issue;
  logic          w_enq;
  logic          w_deq;
  logic          w_full;
  logic          w_ovf;
  logic          w_wr;
  logic          w_unused;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      w_inflight = w_inflight + CW'(r_issued[i]);
  end

  // Squashed slots keep their credit until the response retires.
  assign w_issue = (r_state == S_RUN) && !halt && !redirect_valid &&
                   ((w_inflight + r_cnt) < CW'(FIFO_DEPTH));
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_deq   = out_valid && out_ready && !redirect_valid;
  assign w_enq   = imem_rvalid && r_issued[LATENCY-1] &&
                   r_live[LATENCY-1] && !redirect_valid;
  assign w_ovf   = w_enq && w_full && !w_deq;
  assign w_wr    = w_enq && !w_ovf;
  assign w_unused = ^redirect_pc[1:0];

  assign imem_en    = w_issue;
  assign imem_index = r_pc[31:2];
  assign out_valid  = (r_cnt != '0);
  assign out_instr  = r_finstr[r_rd];
  assign out_pc     = r_fpc[r_rd];
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        r_issued[i] <= 1'b0;
        r_live[i]   <= 1'b0;
        r_spc[i]    <= '0;
      end
    end else begin
      unique case (r_state)
        S_BOOT:  r_state <= halt ? S_HALT : S_RUN;
        S_RUN:   if (halt) r_state <= S_HALT;
        S_HALT:  if (!halt) r_state <= S_RUN;
        default: r_state <= S_BOOT;
      endcase
      if (redirect_valid)
        r_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_issue)
        r_pc <= r_pc + 32'd4;
      if ((imem_rvalid != r_issued[LATENCY-1]) || w_ovf)
        r_err <= 1'b1;
      r_issued[0] <= w_issue;
      r_live[0]   <= w_issue;
      r_spc[0]    <= r_pc;
      for (int i = 1; i < LATENCY; i++) begin
        r_issued[i] <= r_issued[i-1];
        r_live[i]   <= r_live[i-1] && !redirect_valid;
        r_spc[i]    <= r_spc[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fpc[i]    <= '0;
        r_finstr[i] <= 32'h0000_0013;
      end
    end else if (redirect_valid) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_fpc[r_wr]    <= r_spc[LATENCY-1];
        r_finstr[r_wr] <= imem_rdata;
        r_wr           <= r_wr + AW'(1);
      end
      if (w_deq)
        r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_deq);
    end
  end

endmodule
